// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter serialising word/half/byte accesses onto a byte-wide synchronous RAM.
// Optional `MEM_ARBITER_RR_EN selects round-robin arbitration; otherwise load/store has fixed priority over fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rstn_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            n_q, n_d;
  logic                  owner_ls_q, owner_ls_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           result_q, result_d;
  logic                  grant_ls;
  logic                  accept;
  logic [2:0]            offset;
  logic [2:0]            ls_nbytes;

  assign accept = (state_q == S_IDLE) && (if_req || ls_req);

  always_comb begin
    unique case (ls_size)
      2'b00:   ls_nbytes = 3'd1;
      2'b01:   ls_nbytes = 3'd2;
      default: ls_nbytes = 3'd4;
    endcase
  end

`ifdef MEM_ARBITER_RR_EN
  // last_q: 0 = fetch was granted most recently, 1 = load/store was.
  logic last_q, last_d;

  assign grant_ls = ls_req && (!if_req || !last_q);
  assign last_d   = accept ? grant_ls : last_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) last_q <= 1'b0;
    else          last_q <= last_d;
  end
`else
  assign grant_ls = ls_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_ls_d = grant_ls;
          result_d   = 32'h0;
          cnt_d      = 3'd0;
          if (grant_ls) begin
            addr_d  = ls_addr;
            n_d     = ls_nbytes;
            wdata_d = ls_wdata;
            state_d = ls_we ? S_WRITE : S_READ;
          end else begin
            addr_d  = if_addr;
            n_d     = 3'd4;
            wdata_d = 32'h0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        // RAM data lags its address by one cycle, so byte cnt-1 arrives now.
        for (int b = 0; b < 4; b++) begin
          if (cnt_q == 3'(b + 1)) result_d[8*b +: 8] = mem_din;
        end
        if (cnt_q == n_q) state_d = S_DONE;
        else              cnt_d   = cnt_q + 3'd1;
      end
      S_WRITE: begin
        if (cnt_q == n_q - 3'd1) state_d = S_DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      result_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
    end
  end

  // The final read cycle keeps the last address on the bus while its data is captured.
  assign offset = ((state_q == S_READ) && (cnt_q == n_q)) ? (cnt_q - 3'd1) : cnt_q;
  assign mem_a  = addr_q + ADDR_WIDTH'(offset);
  assign mem_wr = (state_q == S_WRITE);

  always_comb begin
    mem_dout = 8'h0;
    if (state_q == S_WRITE) mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  end

  assign if_done  = (state_q == S_DONE) && !owner_ls_q;
  assign ls_done  = (state_q == S_DONE) &&  owner_ls_q;
  assign if_data  = result_q;
  assign ls_rdata = result_q;

endmodule
